// File: rtl/datapath_types_pkg.sv
// Shared fetch-stage datapath types: branch direction counter encoding and the
// branch target buffer entry layout.
package datapath_types_pkg;

  localparam int BP_DEFAULT_ENTRIES = 8;
  // Tag field holds pc[31:IDX_W+2] for the default table size.
  localparam int BP_TAG_W = 32 - $clog2(BP_DEFAULT_ENTRIES) - 2;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bp_ctr_t;

  typedef struct packed {
    logic                valid;
    logic [BP_TAG_W-1:0] tag;
    logic [31:0]         target;
    bp_ctr_t             ctr;
  } btb_entry_t;

endpackage

// File: rtl/bp_sat_counter.sv
// Next-state logic for a 2-bit saturating branch direction counter.
// Moves one step toward ST on taken, toward SNT on not-taken, never wraps.
module bp_sat_counter
  import datapath_types_pkg::*;
(
  input  bp_ctr_t ctr,
  input  logic    taken,
  output bp_ctr_t ctr_next
);

  always_comb begin
    ctr_next = ctr;
    unique case (ctr)
      SNT:     ctr_next = taken ? WNT : SNT;
      WNT:     ctr_next = taken ? WT  : SNT;
      WT:      ctr_next = taken ? ST  : WNT;
      ST:      ctr_next = taken ? ST  : WT;
      default: ctr_next = ctr;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters for the fetch stage.
// Define BRANCH_PRED_STATS_EN to build the resolved-branch/mispredict counters.
module branch_predictor
  import datapath_types_pkg::*;
#(
  parameter  int ENTRIES = 8,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] fetch_pc,
  output logic        pred_control,
  output logic [31:0] pred_branch,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_mispredict,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
);

  // The update port is a one-cycle strobe with no valid/ready handshake: every
  // cycle with upd_valid=1 is exactly one resolved branch and is always accepted.

  function automatic logic [IDX_W-1:0] idx_of(input logic [31:0] pc);
    return pc[IDX_W+1:2];
  endfunction

  // Tables smaller than the default keep only the low BP_TAG_W tag bits.
  function automatic logic [BP_TAG_W-1:0] tag_of(input logic [31:0] pc);
    return BP_TAG_W'(pc[31:IDX_W+2]);
  endfunction

  btb_entry_t table_q [ENTRIES];

  btb_entry_t       rd_entry;
  logic             rd_hit;
  btb_entry_t       up_entry;
  logic             up_hit;
  logic [IDX_W-1:0] up_idx;
  bp_ctr_t          up_ctr_next;

  // Lookup reads the registered table, so a same-cycle update is not visible.
  assign rd_entry     = table_q[idx_of(fetch_pc)];
  assign rd_hit       = rd_entry.valid && (rd_entry.tag == tag_of(fetch_pc));
  assign pred_control = !RST && rd_hit && rd_entry.ctr[1];
  assign pred_branch  = pred_control ? rd_entry.target : 32'd0;

  assign up_idx   = idx_of(upd_pc);
  assign up_entry = table_q[up_idx];
  assign up_hit   = up_entry.valid && (up_entry.tag == tag_of(upd_pc));

  bp_sat_counter u_sat_counter (
    .ctr      (up_entry.ctr),
    .taken    (upd_taken),
    .ctr_next (up_ctr_next)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        table_q[i] <= '{valid: 1'b0, tag: '0, target: 32'd0, ctr: WNT};
      end
    end else if (upd_valid) begin
      if (up_hit) begin
        table_q[up_idx].ctr <= up_ctr_next;
        if (upd_taken) begin
          table_q[up_idx].target <= upd_target;
        end
      end else if (upd_taken) begin
        // Taken miss evicts whatever occupies the slot.
        table_q[up_idx] <= '{valid: 1'b1, tag: tag_of(upd_pc), target: upd_target, ctr: WT};
      end
    end
  end

`ifdef BRANCH_PRED_STATS_EN
  logic [31:0] branches_q;
  logic [31:0] mispredicts_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      branches_q    <= 32'd0;
      mispredicts_q <= 32'd0;
    end else if (upd_valid) begin
      branches_q <= branches_q + 32'd1;
      if (upd_mispredict) begin
        mispredicts_q <= mispredicts_q + 32'd1;
      end
    end
  end

  assign stat_branches    = branches_q;
  assign stat_mispredicts = mispredicts_q;
`else
  assign stat_branches    = 32'd0;
  assign stat_mispredicts = 32'd0;
`endif

  // Word-aligned fetch: the byte offset bits never select anything.
  logic unused_bits;
  assign unused_bits = ^{fetch_pc[1:0], upd_pc[1:0], upd_mispredict};

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (default 8 entries).
module tb_branch_predictor;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] fetch_pc;
  logic        pred_control;
  logic [31:0] pred_branch;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_mispredict;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;

  int n_checks = 0;
  int n_fail   = 0;

  branch_predictor #(.ENTRIES(8)) dut (
    .CLK              (CLK),
    .RST              (RST),
    .fetch_pc         (fetch_pc),
    .pred_control     (pred_control),
    .pred_branch      (pred_branch),
    .upd_valid        (upd_valid),
    .upd_pc           (upd_pc),
    .upd_taken        (upd_taken),
    .upd_target       (upd_target),
    .upd_mispredict   (upd_mispredict),
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
  );

  // Clock / reset
  always #5 CLK = ~CLK;

  task automatic do_reset();
    RST       = 1'b1;
    upd_valid = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  // Drivers: called at a negedge, return at the next negedge after the update edge.
  task automatic drive_update(input logic [31:0] pc, input logic taken,
                              input logic [31:0] tgt, input logic misp);
    upd_valid      = 1'b1;
    upd_pc         = pc;
    upd_taken      = taken;
    upd_target     = tgt;
    upd_mispredict = misp;
    @(negedge CLK);
    upd_valid      = 1'b0;
    upd_mispredict = 1'b0;
  endtask

  task automatic set_fetch(input logic [31:0] pc);
    fetch_pc = pc;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    set_fetch(32'h40);
    n_checks++;
    if (pred_control !== 1'b0 || pred_branch !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_lookup: got ctl=%0b br=%h, want ctl=0 br=00000000", pred_control, pred_branch);
    end
    n_checks++;
    if (stat_branches !== 32'h0 || stat_mispredicts !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_stats: got br=%0d mp=%0d, want 0 0", stat_branches, stat_mispredicts);
    end
  endtask

  task automatic test_train();
    drive_update(32'h40, 1'b1, 32'h100, 1'b0);
    set_fetch(32'h40);
    n_checks++;
    if (pred_control !== 1'b1 || pred_branch !== 32'h100) begin
      n_fail++;
      $display("FAIL train_alloc: got ctl=%0b br=%h, want ctl=1 br=00000100", pred_control, pred_branch);
    end
    set_fetch(32'h44);
    n_checks++;
    if (pred_control !== 1'b0 || pred_branch !== 32'h0) begin
      n_fail++;
      $display("FAIL train_neighbor: got ctl=%0b br=%h, want ctl=0 br=00000000", pred_control, pred_branch);
    end
  endtask

  // Entry 0x40 starts at WT/0x100; walk the counter through both saturation points.
  task automatic test_saturation();
    logic        tk  [12] = '{0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1};
    logic [31:0] tg  [12] = '{32'hdead, 32'h100, 32'h100, 32'h180, 32'h180, 32'hdead,
                              32'hdead, 32'hdead, 32'hdead, 32'hdead, 32'h1c0, 32'h1c0};
    logic        ec  [12] = '{0, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 1};
    logic [31:0] eb  [12] = '{32'h0, 32'h100, 32'h100, 32'h180, 32'h180, 32'h180,
                              32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h1c0};
    for (int i = 0; i < 12; i++) begin
      drive_update(32'h40, tk[i], tg[i], 1'b0);
      set_fetch(32'h40);
      n_checks++;
      if (pred_control !== ec[i] || pred_branch !== eb[i]) begin
        n_fail++;
        $display("FAIL saturation_step%0d: got ctl=%0b br=%h, want ctl=%0b br=%h",
                 i, pred_control, pred_branch, ec[i], eb[i]);
      end
    end
  endtask

  task automatic test_alias();
    do_reset();
    drive_update(32'h40, 1'b1, 32'h100, 1'b0);
    drive_update(32'h60, 1'b1, 32'h200, 1'b0);
    set_fetch(32'h40);
    n_checks++;
    if (pred_control !== 1'b0 || pred_branch !== 32'h0) begin
      n_fail++;
      $display("FAIL alias_evicted: got ctl=%0b br=%h, want ctl=0 br=00000000", pred_control, pred_branch);
    end
    set_fetch(32'h60);
    n_checks++;
    if (pred_control !== 1'b1 || pred_branch !== 32'h200) begin
      n_fail++;
      $display("FAIL alias_new: got ctl=%0b br=%h, want ctl=1 br=00000200", pred_control, pred_branch);
    end
    // Not-taken misses must leave the table alone.
    drive_update(32'h40, 1'b0, 32'h300, 1'b0);
    drive_update(32'h80, 1'b0, 32'h300, 1'b0);
    set_fetch(32'h60);
    n_checks++;
    if (pred_control !== 1'b1 || pred_branch !== 32'h200) begin
      n_fail++;
      $display("FAIL miss_nt_keeps: got ctl=%0b br=%h, want ctl=1 br=00000200", pred_control, pred_branch);
    end
    set_fetch(32'h80);
    n_checks++;
    if (pred_control !== 1'b0 || pred_branch !== 32'h0) begin
      n_fail++;
      $display("FAIL miss_nt_noalloc: got ctl=%0b br=%h, want ctl=0 br=00000000", pred_control, pred_branch);
    end
  endtask

  task automatic test_same_cycle();
    do_reset();
    fetch_pc       = 32'h40;
    upd_valid      = 1'b1;
    upd_pc         = 32'h40;
    upd_taken      = 1'b1;
    upd_target     = 32'h140;
    upd_mispredict = 1'b0;
    #1;
    n_checks++;
    if (pred_control !== 1'b0 || pred_branch !== 32'h0) begin
      n_fail++;
      $display("FAIL same_cycle_before: got ctl=%0b br=%h, want ctl=0 br=00000000", pred_control, pred_branch);
    end
    @(negedge CLK);
    upd_valid = 1'b0;
    #1;
    n_checks++;
    if (pred_control !== 1'b1 || pred_branch !== 32'h140) begin
      n_fail++;
      $display("FAIL same_cycle_after: got ctl=%0b br=%h, want ctl=1 br=00000140", pred_control, pred_branch);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive_update(32'h48, 1'b1, 32'h300, 1'b0);
    set_fetch(32'h48);
    n_checks++;
    if (pred_control !== 1'b1 || pred_branch !== 32'h300) begin
      n_fail++;
      $display("FAIL mid_trained: got ctl=%0b br=%h, want ctl=1 br=00000300", pred_control, pred_branch);
    end
    RST = 1'b1;
    #1;
    n_checks++;
    if (pred_control !== 1'b0 || pred_branch !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_rst_gate: got ctl=%0b br=%h, want ctl=0 br=00000000", pred_control, pred_branch);
    end
    // Update presented during reset must be dropped.
    drive_update(32'h4c, 1'b1, 32'h400, 1'b1);
    RST = 1'b0;
    set_fetch(32'h48);
    n_checks++;
    if (pred_control !== 1'b0 || pred_branch !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_cleared: got ctl=%0b br=%h, want ctl=0 br=00000000", pred_control, pred_branch);
    end
    set_fetch(32'h4c);
    n_checks++;
    if (pred_control !== 1'b0 || pred_branch !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_upd_ignored: got ctl=%0b br=%h, want ctl=0 br=00000000", pred_control, pred_branch);
    end
  endtask

  task automatic test_stats();
    logic [31:0] exp_br;
    logic [31:0] exp_mp;
    logic        mp [5] = '{1, 0, 0, 1, 0};
`ifdef BRANCH_PRED_STATS_EN
    exp_br = 32'd5;
    exp_mp = 32'd2;
`else
    exp_br = 32'd0;
    exp_mp = 32'd0;
`endif
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive_update(32'h100 + 32'(i * 4), i[0], 32'h500, mp[i]);
    end
    // Idle cycles with upd_mispredict high must not count.
    upd_mispredict = 1'b1;
    @(negedge CLK);
    upd_mispredict = 1'b0;
    n_checks++;
    if (stat_branches !== exp_br) begin
      n_fail++;
      $display("FAIL stat_branches: got %0d, want %0d", stat_branches, exp_br);
    end
    n_checks++;
    if (stat_mispredicts !== exp_mp) begin
      n_fail++;
      $display("FAIL stat_mispredicts: got %0d, want %0d", stat_mispredicts, exp_mp);
    end
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    set_fetch(32'h104);
    n_checks++;
    if (stat_branches !== 32'h0 || stat_mispredicts !== 32'h0 || pred_control !== 1'b0) begin
      n_fail++;
      $display("FAIL stat_reset: got br=%0d mp=%0d ctl=%0b, want 0 0 0",
               stat_branches, stat_mispredicts, pred_control);
    end
  endtask

  initial begin
    RST            = 1'b1;
    fetch_pc       = 32'h0;
    upd_valid      = 1'b0;
    upd_pc         = 32'h0;
    upd_taken      = 1'b0;
    upd_target     = 32'h0;
    upd_mispredict = 1'b0;
    @(negedge CLK);
    test_reset();
    test_train();
    test_saturation();
    test_alias();
    test_same_cycle();
    test_reset_mid();
    test_stats();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
